// File: rtl/rv_dm_bridge_pkg.sv
// Shared definitions for the uRV data-memory to Wishbone bridge.
package rv_dm_bridge_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/rv_dm_timeout.sv
// Bus-cycle watchdog: cleared by start, counts while run is high and flags
// the cycle in which TIMEOUT cycles of activity have elapsed.
// TIMEOUT = 0 disables the watchdog entirely.
module rv_dm_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam bit          ENABLE = (TIMEOUT != 0);
  // Count value seen in the last permitted cycle; the abort takes effect
  // at the following edge so the bus sees exactly TIMEOUT active cycles.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Counter: clear on start, advance while running, saturate at LAST.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (ENABLE && run && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = ENABLE && run && (cnt_q == LAST);

endmodule

// File: rtl/rv_dm_wb_bridge.sv
// Data-memory bridge: turns uRV single-cycle load/store requests into
// single-beat Wishbone B4 pipelined master cycles, with bus timeout and a
// sticky error flag.
module rv_dm_wb_bridge
  import rv_dm_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [WB_ADR_W-1:0] cpu_addr_i,
  input  logic [WB_DAT_W-1:0] cpu_data_s_i,
  input  logic [WB_SEL_W-1:0] cpu_data_select_i,
  input  logic                cpu_load_i,
  input  logic                cpu_store_i,
  output logic                cpu_ready_o,
  output logic [WB_DAT_W-1:0] cpu_data_l_o,
  output logic                cpu_load_done_o,
  output logic                cpu_store_done_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                wb_stall_i,
  output logic                bus_err_o,
  input  logic                bus_err_clr_i
);

  state_e state_q, state_d;

  logic                  accept;
  logic                  done_ok;
  logic                  done_err;
  logic                  expired;

  logic [WB_ADR_W-1:2]   adr_q;
  logic [WB_DAT_W-1:0]   dat_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic                  we_q;

  logic                  load_done_q;
  logic                  store_done_q;
  logic [WB_DAT_W-1:0]   data_l_q;
  logic                  bus_err_q;

  // Byte offset never reaches the bus; byte lanes come from the select.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  rv_dm_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (accept),
    .run    (state_q != ST_IDLE),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and completion decode; a real slave response beats the
  // watchdog when both land in the same cycle.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_load_i || cpu_store_i) begin
          accept  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!wb_stall_i && wb_ack_i) begin
          done_ok = 1'b1;
        end else if (!wb_stall_i && wb_err_i) begin
          done_err = 1'b1;
        end else if (expired) begin
          done_err = 1'b1;
        end else if (!wb_stall_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wb_ack_i) begin
          done_ok = 1'b1;
        end else if (wb_err_i || expired) begin
          done_err = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (done_ok || done_err) begin
      state_d = ST_IDLE;
    end
  end

  // Request latch; a store wins over a simultaneous load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
    end else if (accept) begin
      adr_q <= cpu_addr_i[WB_ADR_W-1:2];
      dat_q <= cpu_data_s_i;
      sel_q <= cpu_data_select_i;
      we_q  <= cpu_store_i;
    end
  end

  // Response register: one-cycle done pulse, load data zeroed on failure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      data_l_q     <= '0;
    end else begin
      load_done_q  <= (done_ok || done_err) && !we_q;
      store_done_q <= (done_ok || done_err) && we_q;
      if ((done_ok || done_err) && !we_q) begin
        data_l_q <= done_ok ? wb_dat_i : '0;
      end
    end
  end

  // Sticky bus error; a new error outranks a clear in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_err_q <= 1'b0;
    end else if (done_err) begin
      bus_err_q <= 1'b1;
    end else if (bus_err_clr_i) begin
      bus_err_q <= 1'b0;
    end
  end

  assign cpu_ready_o      = (state_q == ST_IDLE);
  assign cpu_data_l_o     = data_l_q;
  assign cpu_load_done_o  = load_done_q;
  assign cpu_store_done_o = store_done_q;
  assign wb_cyc_o         = (state_q != ST_IDLE);
  assign wb_stb_o         = (state_q == ST_REQ);
  assign wb_we_o          = we_q && (state_q != ST_IDLE);
  assign wb_adr_o         = {adr_q, 2'b00};
  assign wb_sel_o         = sel_q;
  assign wb_dat_o         = dat_q;
  assign bus_err_o        = bus_err_q;

endmodule

// File: tb/tb_rv_dm_wb_bridge.sv
// Self-checking bench for rv_dm_wb_bridge (TIMEOUT = 8).
`timescale 1ns/1ps
module tb_rv_dm_wb_bridge;

  localparam logic [31:0] IDLE_DAT = 32'h5A5A_5A5A;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_s_i = '0;
  logic [3:0]  cpu_data_select_i = '0;
  logic        cpu_load_i = 1'b0;
  logic        cpu_store_i = 1'b0;
  logic        cpu_ready_o;
  logic [31:0] cpu_data_l_o;
  logic        cpu_load_done_o;
  logic        cpu_store_done_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = IDLE_DAT;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_stall_i = 1'b0;
  logic        bus_err_o;
  logic        bus_err_clr_i = 1'b0;

  rv_dm_wb_bridge #(.TIMEOUT(8)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cpu_addr_i       (cpu_addr_i),
    .cpu_data_s_i     (cpu_data_s_i),
    .cpu_data_select_i(cpu_data_select_i),
    .cpu_load_i       (cpu_load_i),
    .cpu_store_i      (cpu_store_i),
    .cpu_ready_o      (cpu_ready_o),
    .cpu_data_l_o     (cpu_data_l_o),
    .cpu_load_done_o  (cpu_load_done_o),
    .cpu_store_done_o (cpu_store_done_o),
    .wb_cyc_o         (wb_cyc_o),
    .wb_stb_o         (wb_stb_o),
    .wb_we_o          (wb_we_o),
    .wb_adr_o         (wb_adr_o),
    .wb_sel_o         (wb_sel_o),
    .wb_dat_o         (wb_dat_o),
    .wb_dat_i         (wb_dat_i),
    .wb_ack_i         (wb_ack_i),
    .wb_err_i         (wb_err_i),
    .wb_stall_i       (wb_stall_i),
    .bus_err_o        (bus_err_o),
    .bus_err_clr_i    (bus_err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {R_ACK, R_ERR, R_NONE} resp_e;

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          stall;
    int          dly;
    resp_e       resp;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_adr;
    logic [31:0] exp_data;
    int          exp_cyc;
    int          exp_stb;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] data;
    int          t0;
    int          lat;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[7];

  int nchk = 0;
  int nerr = 0;
  int cyc_no = 0;
  int n_cyc = 0, n_stb = 0, n_nrdy = 0, n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] sel,
                              input int stall, input int dly, input resp_e resp,
                              input logic [31:0] rdata, input logic exp_we,
                              input logic [31:0] exp_adr, input logic [31:0] exp_data,
                              input int exp_cyc, input int exp_stb, input logic exp_err);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.sel = sel;
    v.stall = stall; v.dly = dly; v.resp = resp; v.rdata = rdata;
    v.exp_we = exp_we; v.exp_adr = exp_adr; v.exp_data = exp_data;
    v.exp_cyc = exp_cyc; v.exp_stb = exp_stb; v.exp_err = exp_err;
    return v;
  endfunction

  always @(posedge clk_i) cyc_no <= cyc_no + 1;

  // Monitor: bus activity counters and scoreboard check of every done pulse.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (wb_cyc_o) n_cyc++;
      if (wb_stb_o) n_stb++;
      if (!cpu_ready_o) n_nrdy++;
      if (cpu_load_done_o || cpu_store_done_o) begin
        sb_t e;
        n_done++;
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_done: got load_done=%b store_done=%b expected no done",
                   cpu_load_done_o, cpu_store_done_o);
        end else begin
          e = sb.pop_front();
          chk("done_kind", 32'({cpu_store_done_o, cpu_load_done_o}), e.we ? 32'd2 : 32'd1);
          chk("done_latency", 32'(cyc_no - e.t0), 32'(e.lat));
          if (!e.we) chk("load_data", cpu_data_l_o, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_sb_empty(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      nchk++;
      nerr++;
      $display("FAIL %s_timeout: got %0d pending completions expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic push_exp(input logic we, input logic [31:0] data, input int lat);
    sb_t e;
    e.we = we; e.data = data; e.t0 = cyc_no; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic do_xfer(input vec_t v);
    tick();
    chk("ready_before", 32'(cpu_ready_o), 32'd1);
    n_cyc = 0; n_stb = 0; n_nrdy = 0;
    cpu_load_i = v.ld; cpu_store_i = v.st; cpu_addr_i = v.addr;
    cpu_data_s_i = v.wdata; cpu_data_select_i = v.sel;
    push_exp(v.exp_we, v.exp_data, v.exp_cyc + 1);
    tick();
    cpu_load_i = 1'b0; cpu_store_i = 1'b0; cpu_addr_i = '1;
    cpu_data_s_i = '0; cpu_data_select_i = '0;
    chk("req_cyc", 32'(wb_cyc_o), 32'd1);
    chk("req_stb", 32'(wb_stb_o), 32'd1);
    chk("req_we", 32'(wb_we_o), 32'(v.exp_we));
    chk("req_adr", wb_adr_o, v.exp_adr);
    chk("req_sel", 32'(wb_sel_o), 32'(v.sel));
    if (v.exp_we) chk("req_dat", wb_dat_o, v.wdata);
    for (int i = 0; i < v.stall; i++) begin
      wb_stall_i = 1'b1;
      tick();
    end
    wb_stall_i = 1'b0;
    if (v.resp != R_NONE) begin
      for (int i = 0; i < v.dly; i++) tick();
      wb_dat_i = v.rdata;
      if (v.resp == R_ACK) wb_ack_i = 1'b1;
      else wb_err_i = 1'b1;
      tick();
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = IDLE_DAT;
    end
    wait_sb_empty("xfer");
    chk("cyc_cycles", 32'(n_cyc), 32'(v.exp_cyc));
    chk("stb_cycles", 32'(n_stb), 32'(v.exp_stb));
    chk("notready_cycles", 32'(n_nrdy), 32'(v.exp_cyc));
    chk("ready_after", 32'(cpu_ready_o), 32'd1);
    chk("bus_err", 32'(bus_err_o), 32'(v.exp_err));
    if (v.exp_err) begin
      tick(); tick();
      chk("bus_err_sticky", 32'(bus_err_o), 32'd1);
      bus_err_clr_i = 1'b1;
      tick();
      bus_err_clr_i = 1'b0;
      chk("bus_err_cleared", 32'(bus_err_o), 32'd0);
    end
  endtask

  initial begin
    int d0;
    //          ld    st    addr          wdata         sel    stl dly resp    rdata         we    exp_adr       exp_data      cyc stb err
    vecs[0] = mk(1'b1, 1'b0, 32'h0000_1004, 32'h0,        4'hF,  0, 0, R_ACK,  32'hCAFE_BABE, 1'b0, 32'h0000_1004, 32'hCAFE_BABE, 1, 1, 1'b0);
    vecs[1] = mk(1'b0, 1'b1, 32'h0000_2002, 32'h1234_5678, 4'h3,  3, 2, R_ACK,  32'h0,        1'b1, 32'h0000_2000, 32'h0,        6, 4, 1'b0);
    vecs[2] = mk(1'b1, 1'b0, 32'h3FFF_FFFF, 32'h0,        4'h8,  1, 1, R_ACK,  32'h0BAD_F00D, 1'b0, 32'h3FFF_FFFC, 32'h0BAD_F00D, 3, 2, 1'b0);
    vecs[3] = mk(1'b1, 1'b0, 32'h0000_3000, 32'h0,        4'hF,  0, 1, R_ERR,  32'h1111_2222, 1'b0, 32'h0000_3000, 32'h0,        2, 1, 1'b1);
    vecs[4] = mk(1'b1, 1'b1, 32'h0000_0044, 32'hA5A5_A5A5, 4'hC,  0, 0, R_ACK,  32'h0,        1'b1, 32'h0000_0044, 32'h0,        1, 1, 1'b0);
    vecs[5] = mk(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,        4'hF,  2, 0, R_ACK,  32'h8000_0001, 1'b0, 32'hFFFF_FFF0, 32'h8000_0001, 3, 3, 1'b0);
    vecs[6] = mk(1'b1, 1'b0, 32'h0000_5000, 32'h0,        4'hF,  0, 0, R_NONE, 32'h0,        1'b0, 32'h0000_5000, 32'h0,        8, 1, 1'b1);

    // Reset state
    @(posedge clk_i);
    #2;
    chk("rst_ready", 32'(cpu_ready_o), 32'd1);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_data_l", cpu_data_l_o, 32'd0);
    chk("rst_dones", 32'({cpu_load_done_o, cpu_store_done_o}), 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    tick();
    rst_i = 1'b0;

    foreach (vecs[i]) do_xfer(vecs[i]);

    // Late ack after the timeout abort must be ignored.
    d0 = n_done;
    wb_ack_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = IDLE_DAT;
    tick(); tick(); tick();
    chk("late_ack_no_done", 32'(n_done - d0), 32'd0);
    chk("late_ack_cyc", 32'(wb_cyc_o), 32'd0);

    // Err coinciding with clear: the flag stays set.
    tick();
    cpu_load_i = 1'b1; cpu_addr_i = 32'h0000_0600;
    push_exp(1'b0, 32'h0, 3);
    tick();
    cpu_load_i = 1'b0;
    tick();
    chk("errclr_wait_state", 32'({wb_cyc_o, wb_stb_o}), 32'd2);
    wb_err_i = 1'b1; bus_err_clr_i = 1'b1; wb_dat_i = 32'hFFFF_0000;
    tick();
    wb_err_i = 1'b0; bus_err_clr_i = 1'b0; wb_dat_i = IDLE_DAT;
    chk("err_beats_clr", 32'(bus_err_o), 32'd1);
    wait_sb_empty("errclr");
    bus_err_clr_i = 1'b1;
    tick();
    bus_err_clr_i = 1'b0;
    chk("errclr_cleared", 32'(bus_err_o), 32'd0);

    // Back-to-back: second request accepted in the done cycle.
    tick();
    cpu_load_i = 1'b1; cpu_addr_i = 32'h0000_0700; cpu_data_select_i = 4'hF;
    push_exp(1'b0, 32'h0102_0304, 2);
    tick();
    cpu_load_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'h0102_0304;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = IDLE_DAT;
    chk("b2b_ready_in_done", 32'(cpu_ready_o), 32'd1);
    cpu_store_i = 1'b1; cpu_addr_i = 32'h0000_0704; cpu_data_s_i = 32'h7777_0000;
    push_exp(1'b1, 32'h0, 2);
    tick();
    cpu_store_i = 1'b0;
    chk("b2b_cyc", 32'(wb_cyc_o), 32'd1);
    chk("b2b_we", 32'(wb_we_o), 32'd1);
    chk("b2b_adr", wb_adr_o, 32'h0000_0704);
    chk("b2b_dat", wb_dat_o, 32'h7777_0000);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    wait_sb_empty("b2b");

    // Reset asserted mid-cycle while in WAIT.
    tick();
    cpu_load_i = 1'b1; cpu_addr_i = 32'h0000_0800;
    tick();
    cpu_load_i = 1'b0;
    tick();
    chk("rstmid_wait_cyc", 32'(wb_cyc_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rstmid_cyc_async", 32'(wb_cyc_o), 32'd0);
    chk("rstmid_stb_async", 32'(wb_stb_o), 32'd0);
    chk("rstmid_ready", 32'(cpu_ready_o), 32'd1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    tick();
    rst_i = 1'b0;
    d0 = n_done;
    tick(); tick();
    chk("rstmid_no_done", 32'(n_done - d0), 32'd0);
    chk("rstmid_ready_after", 32'(cpu_ready_o), 32'd1);
    do_xfer(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
